// File: rtl/sbox_scheduler.sv
// rtl/sbox_scheduler.sv - arbitrates one shared AES S-box between a state requester and a key-schedule requester
module sbox_scheduler #(
    parameter int KEY_PRIORITY = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_data,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out_data,
    input  logic         kw_valid,
    output logic         kw_ready,
    input  logic [31:0]  kw_data,
    output logic         kw_out_valid,
    input  logic         kw_out_ready,
    output logic [31:0]  kw_out_data,
    output logic [7:0]   sbox_in,
    input  logic [7:0]   sbox_out,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        ST_RUN,
        KW_RUN,
        ST_DONE,
        KW_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [3:0]     idx;
    logic [127:0]   src;
    // Results accumulate from the top down; the final byte comes straight from sbox_out.
    logic [119:0]   res;
    logic           last_st;
    logic           key_wins;
    logic           tie;
    logic           st_take;
    logic           kw_take;
    logic           running;

    // Key wins a tie when it has fixed priority, or when state was the last grant.
    assign key_wins = (KEY_PRIORITY != 0) || last_st;
    assign tie      = st_valid && kw_valid;
    assign st_ready = rst_n && (state == IDLE) && !(tie && key_wins);
    assign kw_ready = rst_n && (state == IDLE) && !(tie && !key_wins);
    assign st_take  = st_valid && st_ready;
    assign kw_take  = kw_valid && kw_ready;
    assign running  = (state == ST_RUN) || (state == KW_RUN);

    assign sbox_in      = running ? src[{idx, 3'b000} +: 8] : 8'h00;
    assign st_out_valid = (state == ST_DONE);
    assign kw_out_valid = (state == KW_DONE);
    assign busy         = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: grant in IDLE, count bytes in RUN, wait for the consumer in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (st_take) begin
                    state_nxt = ST_RUN;
                end else if (kw_take) begin
                    state_nxt = KW_RUN;
                end
            end
            ST_RUN:  if (idx == 4'd15) state_nxt = ST_DONE;
            KW_RUN:  if (idx == 4'd3)  state_nxt = KW_DONE;
            ST_DONE: if (st_out_ready) state_nxt = IDLE;
            KW_DONE: if (kw_out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture source, substitute one byte per cycle, publish on the last byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= 4'd0;
            src         <= 128'h0;
            res         <= 120'h0;
            st_out_data <= 128'h0;
            kw_out_data <= 32'h0;
            last_st     <= 1'b1;
        end else if (st_take) begin
            src     <= st_data;
            idx     <= 4'd0;
            last_st <= 1'b1;
        end else if (kw_take) begin
            src     <= {96'h0, kw_data};
            idx     <= 4'd0;
            last_st <= 1'b0;
        end else if (running) begin
            res <= {sbox_out, res[119:8]};
            idx <= idx + 4'd1;
            if ((state == ST_RUN) && (idx == 4'd15)) begin
                st_out_data <= {sbox_out, res};
            end
            if ((state == KW_RUN) && (idx == 4'd3)) begin
                kw_out_data <= {sbox_out, res[119:96]};
            end
        end
    end

endmodule

// File: tb/tb_sbox_scheduler.sv
// tb/tb_sbox_scheduler.sv - directed self-checking bench for sbox_scheduler
module tb_sbox_scheduler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         st_valid = 1'b0, st_out_ready = 1'b0, kw_valid = 1'b0, kw_out_ready = 1'b0;
    logic [127:0] st_data = '0;
    logic [31:0]  kw_data = '0;
    logic         st_ready, st_out_valid, kw_ready, kw_out_valid, busy;
    logic [127:0] st_out_data;
    logic [31:0]  kw_out_data;
    logic [7:0]   sbox_in, sbox_out;

    logic         p_st_valid = 1'b0, p_kw_valid = 1'b0;
    logic         p_st_ready, p_st_out_valid, p_kw_ready, p_kw_out_valid, p_busy;
    logic [127:0] p_st_out_data;
    logic [31:0]  p_kw_out_data;
    logic [7:0]   p_sbox_in, p_sbox_out;

    int checks = 0;
    int failures = 0;

    logic [7:0] sb [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    assign sbox_out   = sb[sbox_in];
    assign p_sbox_out = sb[p_sbox_in];

    always #5 clk = ~clk;

    sbox_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .st_out_valid(st_out_valid), .st_out_ready(st_out_ready), .st_out_data(st_out_data),
        .kw_valid(kw_valid), .kw_ready(kw_ready), .kw_data(kw_data),
        .kw_out_valid(kw_out_valid), .kw_out_ready(kw_out_ready), .kw_out_data(kw_out_data),
        .sbox_in(sbox_in), .sbox_out(sbox_out), .busy(busy)
    );

    sbox_scheduler #(.KEY_PRIORITY(1)) dut_kp (
        .clk(clk), .rst_n(rst_n),
        .st_valid(p_st_valid), .st_ready(p_st_ready), .st_data(128'h0),
        .st_out_valid(p_st_out_valid), .st_out_ready(1'b1), .st_out_data(p_st_out_data),
        .kw_valid(p_kw_valid), .kw_ready(p_kw_ready), .kw_data(32'h03020100),
        .kw_out_valid(p_kw_out_valid), .kw_out_ready(1'b1), .kw_out_data(p_kw_out_data),
        .sbox_in(p_sbox_in), .sbox_out(p_sbox_out), .busy(p_busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        st_valid = 1'b1;
        kw_valid = 1'b1;
        step();
        checks++;
        if ({st_ready, kw_ready} !== 2'b00) begin
            failures++; $display("FAIL reset_ready got=%b exp=00", {st_ready, kw_ready});
        end
        checks++;
        if ({busy, st_out_valid, kw_out_valid} !== 3'b000) begin
            failures++; $display("FAIL reset_status got=%b exp=000", {busy, st_out_valid, kw_out_valid});
        end
        checks++;
        if ({st_out_data, kw_out_data, sbox_in} !== 168'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {st_out_data, kw_out_data, sbox_in});
        end
        st_valid = 1'b0;
        kw_valid = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({st_ready, kw_ready} !== 2'b11) begin
            failures++; $display("FAIL reset_release_ready got=%b exp=11", {st_ready, kw_ready});
        end
    endtask

    task automatic test_state(input logic [127:0] d, input logic [127:0] e);
        logic [127:0] sh;
        st_data = d;
        st_valid = 1'b1;
        st_out_ready = 1'b1;
        #1;
        checks++;
        if (st_ready !== 1'b1) begin
            failures++; $display("FAIL state_ready got=%b exp=1", st_ready);
        end
        step();
        st_valid = 1'b0;
        st_data = ~d;
        checks++;
        if ({busy, st_ready} !== 2'b10) begin
            failures++; $display("FAIL state_busy got=%b exp=10", {busy, st_ready});
        end
        for (int k = 0; k < 16; k++) begin
            sh = d >> (8 * k);
            checks++;
            if ({st_out_valid, sbox_in} !== {1'b0, sh[7:0]}) begin
                failures++; $display("FAIL state_run_byte%0d got=%h exp=%h", k, {st_out_valid, sbox_in}, {1'b0, sh[7:0]});
            end
            step();
        end
        checks++;
        if (st_out_valid !== 1'b1 || st_out_data !== e) begin
            failures++; $display("FAIL state_result got=%b/%h exp=1/%h", st_out_valid, st_out_data, e);
        end
        step();
        checks++;
        if ({st_out_valid, busy} !== 2'b00 || st_out_data !== e) begin
            failures++; $display("FAIL state_after got=%b/%h exp=00/%h", {st_out_valid, busy}, st_out_data, e);
        end
    endtask

    task automatic test_key(input logic [31:0] d, input logic [31:0] e, input logic [127:0] st_hold);
        kw_data = d;
        kw_valid = 1'b1;
        kw_out_ready = 1'b1;
        #1;
        step();
        kw_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (kw_out_valid !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL key_run%0d got=%b%b exp=01", k, kw_out_valid, busy);
            end
            step();
        end
        checks++;
        if (kw_out_valid !== 1'b1 || kw_out_data !== e) begin
            failures++; $display("FAIL key_result got=%b/%h exp=1/%h", kw_out_valid, kw_out_data, e);
        end
        step();
        checks++;
        if (busy !== 1'b0 || kw_out_data !== e || st_out_data !== st_hold) begin
            failures++; $display("FAIL key_after got=%b/%h/%h exp=0/%h/%h", busy, kw_out_data, st_out_data, e, st_hold);
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] e = 128'h638293c31bfc33f5c4eeacea4bc12816;
        st_data = 128'h00112233445566778899aabbccddeeff;
        st_valid = 1'b1;
        st_out_ready = 1'b0;
        #1;
        step();
        st_valid = 1'b0;
        kw_valid = 1'b1;
        for (int k = 0; k < 16; k++) step();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({st_out_valid, busy, st_ready, kw_ready} !== 4'b1100 || st_out_data !== e) begin
                failures++; $display("FAIL bp_hold%0d got=%b/%h exp=1100/%h", k, {st_out_valid, busy, st_ready, kw_ready}, st_out_data, e);
            end
            step();
        end
        st_out_ready = 1'b1;
        step();
        checks++;
        if ({st_out_valid, busy, kw_ready} !== 3'b001) begin
            failures++; $display("FAIL bp_release got=%b exp=001", {st_out_valid, busy, kw_ready});
        end
        kw_valid = 1'b0;
        step();
    endtask

    task automatic test_round_robin;
        int n = 0;
        logic exp_key;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        st_data = 128'h0;
        kw_data = 32'h03020100;
        st_valid = 1'b1;
        kw_valid = 1'b1;
        st_out_ready = 1'b1;
        kw_out_ready = 1'b1;
        #1;
        for (int c = 0; c < 150 && n < 4; c++) begin
            if (st_ready || kw_ready) begin
                exp_key = (n % 2 == 0);
                checks++;
                if ({kw_ready, st_ready} !== {exp_key, ~exp_key}) begin
                    failures++; $display("FAIL rr_grant%0d got=%b exp=%b", n, {kw_ready, st_ready}, {exp_key, ~exp_key});
                end
                n++;
            end
            step();
        end
        st_valid = 1'b0;
        kw_valid = 1'b0;
        checks++;
        if (n != 4) begin
            failures++; $display("FAIL rr_timeout got=%0d exp=4", n);
        end
        for (int c = 0; c < 40 && busy; c++) step();
    endtask

    task automatic test_key_priority;
        int stg = 0;
        int kwg = 0;
        p_st_valid = 1'b1;
        p_kw_valid = 1'b1;
        #1;
        for (int c = 0; c < 80; c++) begin
            if (p_st_ready) stg++;
            if (p_kw_ready) kwg++;
            step();
        end
        p_st_valid = 1'b0;
        p_kw_valid = 1'b0;
        checks++;
        if (stg != 0) begin
            failures++; $display("FAIL kp_state_grants got=%0d exp=0", stg);
        end
        checks++;
        if (kwg < 12) begin
            failures++; $display("FAIL kp_key_grants got=%0d exp>=12", kwg);
        end
    endtask

    task automatic test_reset_mid;
        logic seen = 1'b0;
        st_data = 128'h0f0e0d0c0b0a09080706050403020100;
        st_valid = 1'b1;
        st_out_ready = 1'b1;
        #1;
        step();
        st_valid = 1'b0;
        for (int k = 0; k < 7; k++) step();
        checks++;
        if (sbox_in !== 8'h07) begin
            failures++; $display("FAIL rmid_idx got=%h exp=07", sbox_in);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, st_out_valid, kw_out_valid, st_ready, kw_ready} !== 5'b0 || sbox_in !== 8'h00 || st_out_data !== 128'h0) begin
            failures++; $display("FAIL rmid_async got=%b/%h/%h exp=0/00/0", {busy, st_out_valid, kw_out_valid, st_ready, kw_ready}, sbox_in, st_out_data);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (st_ready !== 1'b1) begin
            failures++; $display("FAIL rmid_ready got=%b exp=1", st_ready);
        end
        for (int c = 0; c < 25; c++) begin
            seen = seen | st_out_valid | busy;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL rmid_stale got=%b exp=0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_state(128'h0, 128'h63636363636363636363636363636363);
        test_state(128'h0f0e0d0c0b0a09080706050403020100, 128'h76abd7fe2b670130c56f6bf27b777c63);
        test_key(32'h09cf4f3c, 32'h018a84eb, 128'h76abd7fe2b670130c56f6bf27b777c63);
        test_key(32'h03020100, 32'h7b777c63, 128'h76abd7fe2b670130c56f6bf27b777c63);
        test_backpressure();
        test_round_robin();
        test_key_priority();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sbox_scheduler.md
SBOX_SCHEDULER -- requirements
Module: sbox_scheduler

Interface
REQ-001 The module SHALL have parameter KEY_PRIORITY, default 0, where 0 selects round-robin tie-break and 1 gives the key requester fixed priority.
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port st_valid, input, 1 bit: the state requester offers a 128-bit block.
REQ-005 Port st_ready, output, 1 bit: the scheduler accepts a state block.
REQ-006 Port st_data, input, 128 bits: state block; byte k is bits [8k+7:8k].
REQ-007 Port st_out_valid, output, 1 bit: the substituted state result is valid.
REQ-008 Port st_out_ready, input, 1 bit: the consumer accepts the state result.
REQ-009 Port st_out_data, output, 128 bits: substituted state; byte k = S(st_data byte k).
REQ-010 Port kw_valid, input, 1 bit: the key-schedule requester offers a 32-bit word.
REQ-011 Port kw_ready, output, 1 bit: the scheduler accepts a key word.
REQ-012 Port kw_data, input, 32 bits: key word, with the same byte order as st_data.
REQ-013 Port kw_out_valid, output, 1 bit: the SubWord result is valid.
REQ-014 Port kw_out_ready, input, 1 bit: the consumer accepts the SubWord result.
REQ-015 Port kw_out_data, output, 32 bits: SubWord result.
REQ-016 Port sbox_in, output, 8 bits: byte driven to the single shared combinational AES S-box.
REQ-017 Port sbox_out, input, 8 bits: S-box result for sbox_in, valid in the same cycle.
REQ-018 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, ST_RUN, KW_RUN, ST_DONE and KW_DONE.
REQ-020 st_ready and kw_ready SHALL be high only in IDLE; a handshake is valid&&ready at a rising edge.
REQ-021 In IDLE, if only one valid is high, that requester SHALL be granted.
REQ-022 If both valids are high, the grant SHALL follow KEY_PRIORITY: with 1, key wins; with 0, the requester not granted last wins.
REQ-023 Only the granted ready SHALL be high in a tie cycle, with the same-cycle combinational choice.
REQ-024 On a handshake, input data SHALL be captured into a source register, the byte index SHALL clear to 0, and the FSM SHALL move to ST_RUN or KW_RUN.
REQ-025 In RUN, sbox_in SHALL equal source byte[idx]; sbox_out SHALL be written to result byte[idx]; idx SHALL increment once per cycle.
REQ-026 ST_RUN SHALL last exactly 16 cycles and KW_RUN exactly 4 cycles; after the last byte the FSM SHALL move to ST_DONE or KW_DONE.
REQ-027 Latency SHALL be fixed: the out_valid rises 17 cycles (state) or 5 cycles (key) after the accepting edge.
REQ-028 In DONE, the out_valid SHALL be high and the out_data SHALL be held stable until out_ready is high at an edge; the FSM SHALL then return to IDLE.
REQ-029 The next request SHALL be accepted no earlier than the cycle after returning to IDLE, giving a minimum of 18 cycles per state operation and 6 per key operation.
REQ-030 The last-grant flag SHALL update only on an accepting handshake.
REQ-031 sbox_in SHALL be 8'h00 outside the RUN states.
REQ-032 out_data SHALL be registered; a requester's out_data SHALL hold its last result until overwritten by its next completion.
REQ-033 Input valid changes during RUN or DONE SHALL have no effect; requesters SHALL hold valid until ready.

Reset
REQ-034 While rst_n is low, the FSM SHALL be IDLE and idx SHALL be 0.
REQ-035 During reset, all out_valid outputs, busy and all data registers SHALL be 0.
REQ-036 During reset, the last-grant flag SHALL favour key, so the first round-robin tie goes to the key requester.
REQ-037 During reset, st_ready and kw_ready SHALL be 0.
REQ-038 Reset asserted mid-operation SHALL discard partial results immediately, with no out_valid pulse.
REQ-039 After reset release, ready SHALL assert in the first cycle.

Verification
REQ-040 Scenario: st_data=128'h0 accepted with st_out_ready=1 -> st_out_valid rises 17 cycles later with st_out_data=128'h63636363636363636363636363636363 for 1 cycle, and busy is low the next cycle.
REQ-041 Scenario: kw_data=32'h09cf4f3c -> kw_out_data=32'h018a84eb after 5 cycles; separately, kw_data=32'h03020100 -> 32'h7b777c63.
REQ-042 Scenario: after reset, st_valid and kw_valid rise in the same cycle (KEY_PRIORITY=0) -> key is granted first; state is granted after the key result handshake; a second tie grants state then key, alternating.
REQ-043 Scenario: KEY_PRIORITY=1 with both requesters continuously valid -> key is always granted and state starves.
REQ-044 Scenario: st_out_ready held low for 10 cycles after st_out_valid -> st_out_data is stable, both readys are 0 and busy is 1; release -> IDLE and ready the next cycle.
REQ-045 Scenario: rst_n pulsed low during ST_RUN at idx=7 -> all outputs are 0 asynchronously; after release, ready is 1 and no stale result appears.
